seg8_pwl_eval: RTL

- Consumer end of the 8-segment activation indexer interface.
- Takes an FP16 fraction f in [0,1) and its 3-bit segment index, then evaluates a programmable piecewise-linear function y = slope[seg]*f + icpt[seg].
- Returns y as FP16 through a 4-stage valid-only pipeline.
- Sits directly after the segment indexer in the activation path of the SSM datapath.

---
 rtl/seg8_pwl_eval.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg8_pwl_eval.sv
// Programmable 8-segment piecewise-linear evaluator: y = slope[seg]*f + icpt[seg].
// FP16 fraction in, FP16 result out through a 4-stage valid-only pipeline.
module seg8_pwl_eval #(
  parameter int          DW        = 16,
  parameter logic [15:0] RST_SLOPE = 16'h1000,
  parameter logic [15:0] RST_ICPT  = 16'h0000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid_i,
  input  logic [DW-1:0] f_i,
  input  logic [2:0]    seg_i,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [DW-1:0] cfg_slope,
  input  logic [DW-1:0] cfg_icpt,
  output logic [DW-1:0] y_o,
  output logic          sat_o,
  output logic          valid_o
);

  logic [15:0] slope_tab [8];
  logic [15:0] icpt_tab  [8];

  logic        s1_valid;
  logic [15:0] s1_fq;
  logic [2:0]  s1_seg;

  logic        s2_valid;
  logic [16:0] s2_prod;
  logic [15:0] s2_icpt;

  logic        s3_valid;
  logic [15:0] s3_sum;
  logic        s3_sat;

  // Coefficient table: a write lands at the edge, so an S2 read in the same
  // cycle still sees the previous entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        slope_tab[i] <= RST_SLOPE;
        icpt_tab[i]  <= RST_ICPT;
      end
    end else if (cfg_we) begin
      slope_tab[cfg_addr] <= cfg_slope;
      icpt_tab[cfg_addr]  <= cfg_icpt;
    end
  end

  // S1: FP16 -> unsigned Q0.16
  logic [4:0]  f_exp;
  logic [9:0]  f_man;
  logic [15:0] fq_next;

  always_comb begin
    f_exp   = f_i[14:10];
    f_man   = f_i[9:0];
    fq_next = 16'({1'b1, f_man, 6'b0} >> (5'd15 - f_exp));
    if (f_i[15] || (f_exp == 5'd0)) begin
      fq_next = 16'h0000;
    end else if (f_exp >= 5'd15) begin
      fq_next = 16'hFFFF;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_fq    <= 16'h0000;
      s1_seg   <= 3'd0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_fq  <= fq_next;
        s1_seg <= seg_i;
      end
    end
  end

  // S2: lookup and signed x unsigned multiply, floor back to Q4.12
  logic [15:0]        slope_rd;
  logic [15:0]        icpt_rd;
  logic signed [32:0] prod_full;
  logic [16:0]        prod_q412;

  always_comb begin
    slope_rd  = slope_tab[s1_seg];
    icpt_rd   = icpt_tab[s1_seg];
    prod_full = $signed(slope_rd) * $signed({1'b0, s1_fq});
    prod_q412 = 17'(prod_full >>> 16);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_prod  <= 17'd0;
      s2_icpt  <= 16'h0000;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= prod_q412;
        s2_icpt <= icpt_rd;
      end
    end
  end

  // S3: add and clip to the Q4.12 range; in range iff the top three bits agree
  logic [17:0] sum_full;
  logic [15:0] sum_sat;
  logic        sat_next;

  always_comb begin
    sum_full = {s2_prod[16], s2_prod} + {{2{s2_icpt[15]}}, s2_icpt};
    sum_sat  = sum_full[15:0];
    sat_next = 1'b0;
    if (!sum_full[17] && (sum_full[16:15] != 2'b00)) begin
      sum_sat  = 16'h7FFF;
      sat_next = 1'b1;
    end else if (sum_full[17] && (sum_full[16:15] != 2'b11)) begin
      sum_sat  = 16'h8000;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid <= 1'b0;
      s3_sum   <= 16'h0000;
      s3_sat   <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sum <= sum_sat;
        s3_sat <= sat_next;
      end
    end
  end

  // S4: Q4.12 -> FP16. Magnitude is at most 2^15, so the exponent stays normal.
  logic        fp_neg;
  logic [16:0] fp_mag;
  logic [4:0]  fp_lead;
  logic [16:0] fp_norm;
  logic [9:0]  fp_man;
  logic [15:0] fp_next;

  always_comb begin
    fp_neg  = s3_sum[15];
    fp_mag  = fp_neg ? (17'd0 - {1'b1, s3_sum}) : {1'b0, s3_sum};
    fp_lead = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (fp_mag[i]) begin
        fp_lead = 5'(i);
      end
    end
    fp_norm = fp_mag << (5'd16 - fp_lead);
    fp_man  = 10'(fp_norm >> 6);
    if (fp_mag == 17'd0) begin
      fp_next = 16'h0000;
    end else begin
      fp_next = {fp_neg, 5'd3 + fp_lead, fp_man};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_o <= 1'b0;
      y_o     <= '0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= s3_valid;
      if (s3_valid) begin
        y_o   <= DW'(fp_next);
        sat_o <= s3_sat;
      end
    end
  end

endmodule
